// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, the last iteration index and the product width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] ITER_LAST = 3'd7;
    localparam int         PROD_W    = 16;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Ripple-carry adder that carries every addition in the multiplier datapath.
// Each stage is a plain full adder, and the carry chain runs from bit 0 upward.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned 8x8 sequential multiplier (IDLE -> RUN x8 -> DONE) built on one adder.
// Defining OVF_FLAG_EN adds a registered ovf output that flags a non-zero upper product byte.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  multiplicand,
    input  logic [WIDTH-1:0]  multiplier,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product,
`ifdef OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic [1:0]        dbg_state
);

    state_t           state, next_state;
    logic [WIDTH-1:0] m_reg, a_reg, q_reg;
    logic [2:0]       iter;
    logic             accept;
    logic             last_iter;

    logic [WIDTH-1:0] addend, sum;
    logic             cout;
    logic [WIDTH-1:0] shift_a, shift_q;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign addend    = q_reg[0] ? m_reg : '0;
    // {cout,sum,Q} >> 1: the adder carry lands in A's MSB, sum LSB moves into Q.
    assign shift_a   = {cout, sum[WIDTH-1:1]};
    assign shift_q   = {sum[0], q_reg[WIDTH-1:1]};
    assign last_iter = (state == RUN) && (iter == ITER_LAST);
    assign dbg_state = state;

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (iter == ITER_LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                accept     = start;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            iter  <= '0;
        end else if (accept) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            iter  <= '0;
        end else if (state == RUN) begin
            a_reg <= shift_a;
            q_reg <= shift_q;
            iter  <= iter + 3'd1;
        end
    end

    // Product only moves on the final shift, so it holds through IDLE and the next RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product <= '0;
        end else if (last_iter) begin
            product <= {shift_a, shift_q};
        end
    end

`ifdef OVF_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       ovf <= 1'b0;
        else if (last_iter) ovf <= (shift_a != '0);
    end
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random operands
// against a plain arithmetic reference, with an expected-product queue.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [1:0]  dbg_state;
`ifdef OVF_FLAG_EN
    logic        ovf;
    logic        last_ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_prod;
    int          obs_lat;
    int          obs_busy;

    seq_multiplier #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
`ifdef OVF_FLAG_EN
        .ovf          (ovf),
`endif
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mult(input logic [7:0] m, input logic [7:0] q);
        logic [15:0] r;
        r = {8'd0, m} * {8'd0, q};
        return r;
    endfunction

    // Latency is counted in cycles from the one in which start is presented.
    task automatic do_mult(input logic [7:0] m, input logic [7:0] q,
                           input bit scramble, input int repulse_at);
        exp_q.push_back(ref_mult(m, q));
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        obs_lat      = 0;
        obs_busy     = 0;
        obs_prod     = 16'hxxxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == repulse_at) begin
                start        = 1'b1;
                multiplicand = 8'h01;
                multiplier   = 8'h01;
            end else begin
                start = 1'b0;
                if (scramble) begin
                    multiplicand = 8'($urandom);
                    multiplier   = 8'($urandom);
                end
            end
            if (done) begin
                obs_lat  = i;
                obs_prod = product;
`ifdef OVF_FLAG_EN
                last_ovf = ovf;
`endif
                break;
            end
            if (busy) obs_busy++;
        end
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
        checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", dbg_state); end
`ifdef OVF_FLAG_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_corners;
        logic [7:0]  tm[3];
        logic [7:0]  tq[3];
        logic [15:0] exp;
        tm = '{8'hFF, 8'h00, 8'h0F};
        tq = '{8'hFF, 8'hA5, 8'h0F};
        for (int k = 0; k < 3; k++) begin
            do_mult(tm[k], tq[k], 1'b0, 0);
            exp = exp_q.pop_front();
            checks++; if (obs_prod !== exp) begin errors++; $display("FAIL corner_product %h*%h got=%h exp=%h", tm[k], tq[k], obs_prod, exp); end
            checks++; if (obs_lat !== 9) begin errors++; $display("FAIL corner_latency %h*%h got=%0d exp=9", tm[k], tq[k], obs_lat); end
            checks++; if (obs_busy !== 8) begin errors++; $display("FAIL corner_busy_cycles %h*%h got=%0d exp=8", tm[k], tq[k], obs_busy); end
`ifdef OVF_FLAG_EN
            checks++; if (last_ovf !== (exp[15:8] != 8'h00)) begin errors++; $display("FAIL corner_ovf %h*%h got=%b exp=%b", tm[k], tq[k], last_ovf, exp[15:8] != 8'h00); end
`endif
        end
    endtask

    task automatic test_idle_hold;
        logic [15:0] exp;
        do_mult(8'hC3, 8'h5A, 1'b1, 0);
        exp = exp_q.pop_front();
        checks++; if (obs_prod !== exp) begin errors++; $display("FAIL hold_product got=%h exp=%h", obs_prod, exp); end
        repeat (3) begin
            @(negedge clk);
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done got=%b exp=0", done); end
        checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL hold_state got=%b exp=00", dbg_state); end
        checks++; if (product !== exp) begin errors++; $display("FAIL hold_idle_product got=%h exp=%h", product, exp); end
    endtask

    task automatic test_restart_ignored;
        logic [15:0] exp;
        do_mult(8'h12, 8'h34, 1'b0, 3);
        exp = exp_q.pop_front();
        checks++; if (obs_prod !== 16'h03A8 || obs_prod !== exp) begin errors++; $display("FAIL restart_product got=%h exp=03a8", obs_prod); end
        checks++; if (obs_lat !== 9) begin errors++; $display("FAIL restart_latency got=%0d exp=9", obs_lat); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        int          first_lat;
        int          gap;
        int          busy2;
        exp_q.push_back(ref_mult(8'h03, 8'h05));
        exp_q.push_back(ref_mult(8'h10, 8'h10));
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'h03;
        multiplier   = 8'h05;
        first_lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            multiplicand = 8'h10;
            multiplier   = 8'h10;
            if (done) begin
                first_lat = i;
                exp = exp_q.pop_front();
                checks++; if (product !== exp) begin errors++; $display("FAIL b2b_first_product got=%h exp=%h", product, exp); end
                break;
            end
        end
        checks++; if (first_lat !== 9) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=9", first_lat); end
        gap   = 0;
        busy2 = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_immediate_run got=%b exp=1", busy); end
            end
            if (done) begin
                gap = j;
                exp = exp_q.pop_front();
                checks++; if (product !== exp) begin errors++; $display("FAIL b2b_second_product got=%h exp=%h", product, exp); end
                break;
            end
            if (busy) busy2++;
        end
        checks++; if (gap !== 9) begin errors++; $display("FAIL b2b_done_gap got=%0d exp=9", gap); end
        checks++; if (busy2 !== 8) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=8", busy2); end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] exp;
        int          pulses;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 8'h55;
        multiplier   = 8'h66;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_done got=%b exp=0", done); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midrun_product got=%h exp=0000", product); end
        checks++; if (dbg_state !== 2'b00) begin errors++; $display("FAIL midrun_state got=%b exp=00", dbg_state); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrun_no_done got=%0d exp=0", pulses); end
        do_mult(8'h07, 8'h09, 1'b0, 0);
        exp = exp_q.pop_front();
        checks++; if (obs_prod !== exp) begin errors++; $display("FAIL midrun_after_product got=%h exp=%h", obs_prod, exp); end
        checks++; if (obs_lat !== 9) begin errors++; $display("FAIL midrun_after_latency got=%0d exp=9", obs_lat); end
    endtask

    task automatic test_random;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
        int          rp;
        for (int n = 0; n < 1000; n++) begin
            m  = 8'($urandom);
            q  = 8'($urandom);
            rp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            do_mult(m, q, 1'b1, rp);
            exp = exp_q.pop_front();
            checks++; if (obs_prod !== exp) begin errors++; $display("FAIL rand_product %h*%h got=%h exp=%h", m, q, obs_prod, exp); end
            checks++; if (obs_lat !== 9) begin errors++; $display("FAIL rand_latency %h*%h got=%0d exp=9", m, q, obs_lat); end
`ifdef OVF_FLAG_EN
            checks++; if (last_ovf !== (exp[15:8] != 8'h00)) begin errors++; $display("FAIL rand_ovf %h*%h got=%b", m, q, last_ovf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_idle_hold();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
